pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, stall and flush. It generalises the fixed IF/ID register to any payload width and any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It decouples upstream from downstream backpressure without a combinational ready path through the payload. It is instantiated once per stage boundary in the core pipeline.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (for example {Instr, PCPlus4}).
- NOP_VALUE, '0, payload presented on out_data when out_valid=0; a flushed instruction reads as NOP.
- CNT_W, 16, width of the performance counters (used only with PIPE_STAGE_PERF_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- stall  in  1  hazard-unit stall: freeze the stage.
- flush  in  1  hazard-unit flush: discard all held entries.
- out_valid  out  1  out_data is a valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to the next stage.
- stall_cnt  out  CNT_W  cycles with stall=1 (only with PIPE_STAGE_PERF_EN).
- flush_cnt  out  CNT_W  cycles with flush=1 (only with PIPE_STAGE_PERF_EN).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1 (only with PIPE_STAGE_PERF_EN).

## Operation
Definitions:
- accept = in_valid & in_ready.
- deliver = out_valid & out_ready.

State machine over the entries held:

| State | Held entries | main_valid | skid_valid |
|---|---|---|---|
| EMPTY | 0 | 0 | 0 |
| ONE | 1 | 1 | 0 |
| FULL | 2 | 1 | 1 |

Combinational outputs:
- in_ready = (state != FULL) & !stall.
- out_valid = main_valid & !stall.
- out_data = out_valid ? main_data : NOP_VALUE.

Transitions, applied when flush=0 and stall=0:
- EMPTY: accept -> ONE, main <= in_data.
- ONE, accept and deliver: stay ONE, main <= in_data.
- ONE, accept only: -> FULL, skid <= in_data.
- ONE, deliver only: -> EMPTY.
- FULL, deliver: -> ONE, main <= skid. No accept is possible because in_ready=0.
- Any state with no accept and no deliver: hold.

Priority rules:
- flush has priority over everything: next state EMPTY. Both entries are dropped, and so is any word accepted in the same cycle.
- stall=1 with flush=0: state and all registers are held, and no transfer occurs on either side.
- Payload ordering is strictly FIFO. Data is never duplicated or lost except by flush.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=NOP_VALUE, state EMPTY, all counters 0.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (one cycle).
- Throughput: one word per cycle when out_ready=1 continuously.
- out_ready dropping while in ONE: the next accepted word goes to skid (state FULL), and in_ready falls in the following cycle. No combinational path exists from out_ready to in_ready.
- A flush asserted in cycle N makes out_valid=0 and out_data=NOP_VALUE after edge N. in_ready=1 after edge N unless stall=1.
- stall and flush asserted together: flush applies.
- reset asserted mid-operation overrides flush and stall, and returns the block to the reset values on the next edge.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - stall_cnt, flush_cnt and bubble_cnt exist.
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1.
  - Counters clear only on reset; flush does not clear them.
- PIPE_STAGE_PERF_EN undefined: these ports and the counter logic are absent, and the rest of the behaviour is identical.

## Structure
- Package pipe_pkg holds:
  - the state enum pipe_state_e (EMPTY, ONE, FULL);
  - the default width constants for the IF/ID payload (INSTR_W=32, PC_W=32);
  - the packed struct if_id_payload_t {instr, pc_plus4}.
- Sub-module sat_counter (parameter CNT_W; ports clk, reset, inc, count) is instantiated three times under PIPE_STAGE_PERF_EN.

## Test plan
- Reset release, idle inputs -> in_ready=1, out_valid=0, out_data=NOP_VALUE, counters 0.
- Streaming: in_data=1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4, each one cycle later, with no bubbles.
- Backpressure: stream 0xA, 0xB, 0xC, and drop out_ready for 2 cycles as 0xB is accepted.
  - Expect state FULL and in_ready=0.
  - On release, expect the output order 0xA, 0xB, 0xC with no loss or duplication.
- Flush in FULL, with in_valid=1 and in_data=0x55 in the same cycle:
  - Next cycle: out_valid=0, out_data=NOP_VALUE.
  - 0x55 never appears on the output.
- stall=1 for 3 cycles in ONE holding 0x77: out_valid=0 and in_ready=0 throughout; after release, out_data=0x77 and out_valid=1. With PIPE_STAGE_PERF_EN: stall_cnt=3.
- CNT_W=2, flush held 6 cycles with PIPE_STAGE_PERF_EN -> flush_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the core pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus4;
  } if_id_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stage performance statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Stops at all-ones rather than wrapping so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer, stall and flush.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = $bits(if_id_payload_t),
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
`ifdef PIPE_STAGE_PERF_EN
  ,parameter int               CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt
  ,output logic [CNT_W-1:0] flush_cnt
  ,output logic [CNT_W-1:0] bubble_cnt
`endif
);

  pipe_state_e       r_state;
  pipe_state_e       w_stateNext;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_accept;
  logic              w_deliver;
  logic              w_loadMainIn;
  logic              w_loadMainSkid;
  logic              w_loadSkid;

  // in_ready depends only on registered state and stall, never on out_ready.
  assign in_ready  = (r_state != FULL) && !stall;
  assign out_valid = (r_state != EMPTY) && !stall;
  assign out_data  = out_valid ? r_main : NOP_VALUE;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  always_comb begin
    w_stateNext    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_stateNext  = ONE;
          w_loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_deliver) begin
          w_loadMainIn = 1'b1;
        end else if (w_accept) begin
          w_stateNext = FULL;
          w_loadSkid  = 1'b1;
        end else if (w_deliver) begin
          w_stateNext = EMPTY;
        end
      end
      FULL: begin
        if (w_deliver) begin
          w_stateNext    = ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_stateNext = EMPTY;
    endcase
    // Flush drops both held entries and any word accepted this cycle.
    if (flush) begin
      w_stateNext = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_loadMainIn) begin
        r_main <= in_data;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic w_bubble;

  assign w_bubble = !out_valid && out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubbleCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble),
    .count (bubble_cnt)
  );
`endif

endmodule
